// File: rtl/tdc_capture_ctrl.sv
// TDC capture front-end: synchronizes start/stop events, samples the Gray-coded ring oscillator
// and counts reference cycles between events, then issues a fixed-width enable strobe.
module tdc_capture_ctrl #(
  parameter int unsigned size_of_counters = 8,
  parameter int unsigned enable_len       = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_in,
  input  logic                        stop_in,
  input  logic [size_of_counters-1:0] ro_gray,
  output logic [size_of_counters-1:0] Coarse,
  output logic [size_of_counters-1:0] Fine_START,
  output logic [size_of_counters-1:0] Fine_STOP,
  output logic                        enable,
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned N = size_of_counters;
  localparam logic [N-1:0] CntOne  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] CntMax  = {N{1'b1}};
  localparam logic [N-1:0] CntLast = {{(N-1){1'b1}}, 1'b0};
  localparam logic [3:0]   StrbLast = 4'(enable_len - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStrobe} state_e;

  state_e state_q, state_d;

  logic start_meta_q, start_sync_q, start_hist_q;
  logic stop_meta_q, stop_sync_q, stop_hist_q;
  logic start_ev, stop_ev;

  logic [N-1:0] sample;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] coarse_q, coarse_d;
  logic [N-1:0] fine_start_q, fine_start_d;
  logic [N-1:0] fine_stop_q, fine_stop_d;
  logic         overflow_q, overflow_d;
  logic [3:0]   strb_q, strb_d;
  logic         enable_q, enable_d;
  logic         busy_d;

  // History keeps running in every state so a level held through STROBE is not re-detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta_q <= 1'b0;
      start_sync_q <= 1'b0;
      start_hist_q <= 1'b0;
      stop_meta_q  <= 1'b0;
      stop_sync_q  <= 1'b0;
      stop_hist_q  <= 1'b0;
    end else begin
      start_meta_q <= start_in;
      start_sync_q <= start_meta_q;
      start_hist_q <= start_sync_q;
      stop_meta_q  <= stop_in;
      stop_sync_q  <= stop_meta_q;
      stop_hist_q  <= stop_sync_q;
    end
  end

  assign start_ev = start_sync_q & ~start_hist_q;
  assign stop_ev  = stop_sync_q & ~stop_hist_q;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    sample = '0;
    for (int i = 0; i < int'(N); i++) begin
      sample[i] = ^(ro_gray >> i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_ev) begin
          state_d = stop_ev ? StStrobe : StRun;
        end
      end
      StRun: begin
        if (stop_ev || (cnt_q == CntLast)) begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (strb_q == StrbLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    enable_d = (state_q == StStrobe);
    busy_d   = (state_q != StIdle);
  end

  always_comb begin
    cnt_d        = cnt_q;
    coarse_d     = coarse_q;
    fine_start_d = fine_start_q;
    fine_stop_d  = fine_stop_q;
    overflow_d   = overflow_q;
    strb_d       = 4'd0;
    unique case (state_q)
      StIdle: begin
        if (start_ev) begin
          fine_start_d = sample;
          cnt_d        = '0;
          overflow_d   = 1'b0;
          if (stop_ev) begin
            coarse_d    = '0;
            fine_stop_d = sample;
          end
        end
      end
      StRun: begin
        if (stop_ev) begin
          coarse_d    = cnt_q + CntOne;
          fine_stop_d = sample;
        end else begin
          cnt_d = cnt_q + CntOne;
          // Saturation: the count would become all-ones, so end the measurement here.
          if (cnt_q == CntLast) begin
            coarse_d    = CntMax;
            fine_stop_d = sample;
            overflow_d  = 1'b1;
          end
        end
      end
      StStrobe: begin
        strb_d = strb_q + 4'd1;
      end
      default: begin
        strb_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      coarse_q     <= '0;
      fine_start_q <= '0;
      fine_stop_q  <= '0;
      overflow_q   <= 1'b0;
      strb_q       <= 4'd0;
      enable_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      coarse_q     <= coarse_d;
      fine_start_q <= fine_start_d;
      fine_stop_q  <= fine_stop_d;
      overflow_q   <= overflow_d;
      strb_q       <= strb_d;
      enable_q     <= enable_d;
    end
  end

  assign Coarse     = coarse_q;
  assign Fine_START = fine_start_q;
  assign Fine_STOP  = fine_stop_q;
  assign overflow   = overflow_q;
  assign enable     = enable_q;
  assign busy       = busy_d;

endmodule

// File: tb/tb_tdc_capture_ctrl.sv
// Bench for tdc_capture_ctrl: three instances (enable_len 1, 2, 4) share stimulus and are
// compared every cycle against an edge-indexed behavioural model, plus table/hand sequences.
module tb_tdc_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_r = 1'b0;
  logic       stop_r = 1'b0;
  logic [7:0] ro_r = 8'h00;

  logic [7:0] coarse_w[3];
  logic [7:0] fs_w[3];
  logic [7:0] fp_w[3];
  logic       en_w[3];
  logic       busy_w[3];
  logic       ovf_w[3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdc_capture_ctrl #(.size_of_counters(8), .enable_len(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start_in(start_r), .stop_in(stop_r), .ro_gray(ro_r),
    .Coarse(coarse_w[0]), .Fine_START(fs_w[0]), .Fine_STOP(fp_w[0]),
    .enable(en_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0])
  );
  tdc_capture_ctrl #(.size_of_counters(8), .enable_len(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start_in(start_r), .stop_in(stop_r), .ro_gray(ro_r),
    .Coarse(coarse_w[1]), .Fine_START(fs_w[1]), .Fine_STOP(fp_w[1]),
    .enable(en_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1])
  );
  tdc_capture_ctrl #(.size_of_counters(8), .enable_len(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .start_in(start_r), .stop_in(stop_r), .ro_gray(ro_r),
    .Coarse(coarse_w[2]), .Fine_START(fs_w[2]), .Fine_STOP(fp_w[2]),
    .enable(en_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2])
  );

  // Model: events are derived from input levels sampled at past edges; measurement state is kept
  // as edge numbers (start edge, capture edge) rather than a state machine.
  int         lk[3] = '{1, 2, 4};
  int         e = 0;
  bit         sh_s[3];
  bit         sh_p[3];
  bit         m_run[3];
  int         m_start[3];
  int         m_cap[3];
  logic [7:0] m_coarse[3];
  logic [7:0] m_fs[3];
  logic [7:0] m_fp[3];
  bit         m_ovf[3];

  function automatic logic [7:0] gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_run[k] = 1'b0;
      m_start[k] = 0;
      m_cap[k] = -100;
      m_coarse[k] = 8'h00;
      m_fs[k] = 8'h00;
      m_fp[k] = 8'h00;
      m_ovf[k] = 1'b0;
      sh_s[k] = 1'b0;
      sh_p[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit sev, pev, idle;
    int d;
    e++;
    sev = sh_s[1] && !sh_s[2];
    pev = sh_p[1] && !sh_p[2];
    sh_s[2] = sh_s[1]; sh_s[1] = sh_s[0]; sh_s[0] = start_r;
    sh_p[2] = sh_p[1]; sh_p[1] = sh_p[0]; sh_p[0] = stop_r;
    for (int k = 0; k < 3; k++) begin
      idle = !m_run[k] && (e >= m_cap[k] + lk[k] + 1);
      if (idle && sev) begin
        m_fs[k] = ro_r ^ (ro_r >> 1) ^ (ro_r >> 2) ^ (ro_r >> 3) ^ (ro_r >> 4) ^ (ro_r >> 5)
                  ^ (ro_r >> 6) ^ (ro_r >> 7);
        m_ovf[k] = 1'b0;
        if (pev) begin
          m_coarse[k] = 8'h00;
          m_fp[k] = m_fs[k];
          m_cap[k] = e;
        end else begin
          m_run[k] = 1'b1;
          m_start[k] = e;
        end
      end else if (m_run[k]) begin
        d = e - m_start[k];
        if (pev || d == 255) begin
          m_coarse[k] = 8'(d);
          m_fp[k] = ro_r ^ (ro_r >> 1) ^ (ro_r >> 2) ^ (ro_r >> 3) ^ (ro_r >> 4) ^ (ro_r >> 5)
                    ^ (ro_r >> 6) ^ (ro_r >> 7);
          m_ovf[k] = !pev;
          m_cap[k] = e;
          m_run[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp, got;
    bit en, bsy;
    for (int k = 0; k < 3; k++) begin
      en  = (e >= m_cap[k] + 1) && (e <= m_cap[k] + lk[k]);
      bsy = m_run[k] || ((e >= m_cap[k]) && (e <= m_cap[k] + lk[k] - 1));
      exp = {5'd0, m_coarse[k], m_fs[k], m_fp[k], m_ovf[k], en, bsy};
      got = {5'd0, coarse_w[k], fs_w[k], fp_w[k], ovf_w[k], en_w[k], busy_w[k]};
      chk($sformatf("model_L%0d_e%0d", lk[k], e), got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int         sep;     // stop delay after start in cycles; -1 = no stop
    logic [7:0] fs;
    logic [7:0] fp;
    logic [7:0] coarse;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int total, cnt_en[3];

    vecs[0] = '{sep: 5,   fs: 8'h12, fp: 8'h47, coarse: 8'd5,   ovf: 1'b0};
    vecs[1] = '{sep: 0,   fs: 8'h80, fp: 8'h80, coarse: 8'd0,   ovf: 1'b0};
    vecs[2] = '{sep: 1,   fs: 8'h00, fp: 8'hFF, coarse: 8'd1,   ovf: 1'b0};
    vecs[3] = '{sep: 3,   fs: 8'hA5, fp: 8'h5A, coarse: 8'd3,   ovf: 1'b0};
    vecs[4] = '{sep: 254, fs: 8'h33, fp: 8'hCC, coarse: 8'd254, ovf: 1'b0};
    vecs[5] = '{sep: -1,  fs: 8'h01, fp: 8'hFE, coarse: 8'hFF,  ovf: 1'b1};
    vecs[6] = '{sep: 40,  fs: 8'h7F, fp: 8'h80, coarse: 8'd40,  ovf: 1'b0};

    model_reset();
    #1;
    chk("reset_outputs", {coarse_w[1], fs_w[1], fp_w[1], 5'd0, ovf_w[1], en_w[1], busy_w[1]}, 0);
    ticks(2);
    rst_n = 1'b1;
    ticks(3);

    // Table-driven measurements.
    foreach (vecs[v]) begin
      ro_r = gray(vecs[v].fs);
      start_r = 1'b1;
      stop_r = (vecs[v].sep == 0);
      total = (vecs[v].sep < 0) ? 270 : vecs[v].sep + 8;
      for (int j = 0; j < total; j++) begin
        tick();
        if (j + 1 == vecs[v].sep) stop_r = 1'b1;
        if (j == 2) ro_r = gray(vecs[v].fp);
      end
      start_r = 1'b0;
      stop_r = 1'b0;
      ticks(8);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("vec%0d_L%0d_result", v, lk[k]),
            {7'd0, coarse_w[k], fs_w[k], fp_w[k], ovf_w[k]},
            {7'd0, vecs[v].coarse, vecs[v].fs, vecs[v].fp, vecs[v].ovf});
      end
    end

    // Stop alone in IDLE is ignored.
    stop_r = 1'b1;
    ticks(5);
    chk("stop_idle_busy", busy_w[1], 1'b0);
    chk("stop_idle_coarse", coarse_w[1], 8'd40);
    stop_r = 1'b0;
    ticks(4);

    // Second start during RUN does not re-arm.
    ro_r = gray(8'h11);
    start_r = 1'b1;
    ticks(4);
    start_r = 1'b0;
    ro_r = gray(8'h22);
    ticks(3);
    start_r = 1'b1;
    ticks(4);
    stop_r = 1'b1;
    ro_r = gray(8'h33);
    ticks(3);
    chk("rerun_fine_start", fs_w[1], 8'h11);
    chk("rerun_fine_stop", fp_w[1], 8'h33);
    chk("rerun_coarse", coarse_w[1], 8'd11);
    start_r = 1'b0;
    stop_r = 1'b0;
    ticks(8);

    // Start during STROBE: ignored by the long-strobe instance, taken by the short ones.
    ro_r = gray(8'h44);
    start_r = 1'b1;
    stop_r = 1'b1;
    ticks(3);
    start_r = 1'b0;
    stop_r = 1'b0;
    ticks(1);
    start_r = 1'b1;
    ro_r = gray(8'h55);
    ticks(3);
    chk("strobe_start_L4", fs_w[2], 8'h44);
    chk("strobe_start_L1", fs_w[0], 8'h55);
    ticks(8);
    chk("held_level_L4", {fs_w[2], busy_w[2]}, {8'h44, 1'b0});
    start_r = 1'b0;
    ticks(3);
    start_r = 1'b1;
    ro_r = gray(8'h66);
    ticks(3);
    chk("new_edge_L4", fs_w[2], 8'h66);
    stop_r = 1'b1;
    ticks(8);
    start_r = 1'b0;
    stop_r = 1'b0;
    ticks(8);

    // Enable pulse width per instance.
    ro_r = gray(8'h0F);
    start_r = 1'b1;
    stop_r = 1'b1;
    cnt_en = '{0, 0, 0};
    for (int j = 0; j < 14; j++) begin
      tick();
      for (int k = 0; k < 3; k++) cnt_en[k] += int'(en_w[k]);
    end
    for (int k = 0; k < 3; k++) chk($sformatf("enable_width_L%0d", lk[k]), cnt_en[k], lk[k]);
    start_r = 1'b0;
    stop_r = 1'b0;
    ticks(6);

    // Gray decode over every code via simultaneous start/stop.
    for (int v = 0; v < 256; v++) begin
      ro_r = gray(8'(v));
      start_r = 1'b1;
      stop_r = 1'b1;
      ticks(3);
      chk($sformatf("gray_%0h", v), {fs_w[0], fp_w[0]}, {8'(v), 8'(v)});
      start_r = 1'b0;
      stop_r = 1'b0;
      ticks(6);
    end

    // Asynchronous reset mid-RUN.
    ro_r = gray(8'h9C);
    start_r = 1'b1;
    ticks(6);
    chk("pre_reset_busy", busy_w[1], 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_reset_L%0d", lk[k]),
          {coarse_w[k], fs_w[k], fp_w[k], 5'd0, ovf_w[k], en_w[k], busy_w[k]}, 0);
    end
    start_r = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    cnt_en = '{0, 0, 0};
    for (int j = 0; j < 10; j++) begin
      tick();
      for (int k = 0; k < 3; k++) cnt_en[k] += int'(en_w[k]);
    end
    chk("no_enable_after_reset", cnt_en[0] + cnt_en[1] + cnt_en[2], 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 7) == 0) start_r = ~start_r;
      if ($urandom_range(0, 7) == 0) stop_r = ~stop_r;
      ro_r = 8'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
